// File: rtl/enigma_pkg.sv
// Shared constants, state encoding and ASCII helpers for the enigma stream feeder.
package enigma_pkg;

  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_Z  = 8'h5A;
  localparam logic [7:0] ASCII_a  = 8'h61;
  localparam logic [7:0] ASCII_z  = 8'h7A;
  localparam logic [7:0] ASCII_Q  = 8'h3F;
  localparam logic [7:0] CASE_BIT = 8'h20;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    OUT
  } feeder_state_t;

  function automatic logic is_lower(input logic [7:0] b);
    return (b >= ASCII_a) && (b <= ASCII_z);
  endfunction

  function automatic logic is_letter(input logic [7:0] b);
    return ((b >= ASCII_A) && (b <= ASCII_Z)) || is_lower(b);
  endfunction

  function automatic logic [7:0] to_upper(input logic [7:0] b);
    return b & ~CASE_BIT;
  endfunction

  // The '?' error marker is never case-adjusted.
  function automatic logic [7:0] restore_case(input logic [7:0] res, input logic lower);
    if (res == ASCII_Q) return res;
    return res | (lower ? CASE_BIT : 8'h00);
  endfunction

endpackage

// File: rtl/enigma_byte_fifo.sv
// Synchronous show-ahead FIFO with full/empty flags and an occupancy count.
module enigma_byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/enigma_stream_feeder.sv
// Host byte stream front-end for the enigma core: buffers bytes, sends letters one at a
// time to the core, bypasses non-letters, restores case and emits in input order.
module enigma_stream_feeder
  import enigma_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  output logic        core_valid,
  output logic [7:0]  core_din,
  input  logic        core_done,
  input  logic [7:0]  core_dout,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        busy,
  output logic        err_timeout,
  output logic [15:0] char_count
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  feeder_state_t   state;
  logic [TW-1:0]   timer;
  logic            cur_lower;

  logic            fifo_push;
  logic            fifo_pop;
  logic [7:0]      fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   fifo_count;

  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && !fifo_full;
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign busy      = (state != IDLE) || (fifo_count != '0);

  enigma_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (s_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // core_din keeps the upper-cased letter from the ISSUE pulse until the next letter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      cur_lower   <= 1'b0;
      core_valid  <= 1'b0;
      core_din    <= '0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      err_timeout <= 1'b0;
      char_count  <= '0;
    end else begin
      core_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur_lower <= is_lower(fifo_dout);
            if (is_letter(fifo_dout)) begin
              core_valid <= 1'b1;
              core_din   <= to_upper(fifo_dout);
              state      <= ISSUE;
            end else begin
              m_valid <= 1'b1;
              m_data  <= fifo_dout;
              state   <= OUT;
            end
          end
        end
        ISSUE: begin
          timer <= '0;
          if (core_done) begin
            m_valid <= 1'b1;
            m_data  <= restore_case(core_dout, cur_lower);
            state   <= OUT;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (core_done) begin
            m_valid <= 1'b1;
            m_data  <= restore_case(core_dout, cur_lower);
            state   <= OUT;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            m_valid     <= 1'b1;
            m_data      <= ASCII_Q;
            err_timeout <= 1'b1;
            state       <= OUT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        OUT: begin
          if (m_ready) begin
            m_valid    <= 1'b0;
            char_count <= char_count + 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_stream_feeder.sv
// Scoreboard bench for enigma_stream_feeder with a behavioural core (dout = din + 1).
module tb_enigma_stream_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        core_valid;
  logic [7:0]  core_din;
  logic        core_done;
  logic [7:0]  core_dout;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic        busy;
  logic        err_timeout;
  logic [15:0] char_count;

  enigma_stream_feeder #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (64)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .core_valid  (core_valid),
    .core_din    (core_din),
    .core_done   (core_done),
    .core_dout   (core_dout),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .busy        (busy),
    .err_timeout (err_timeout),
    .char_count  (char_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] din_q[$];

  int         core_lat    = 3;
  bit         core_on     = 1'b1;
  bit         core_pend   = 1'b0;
  int         core_cnt    = 0;
  logic [7:0] core_cap    = '0;
  int         n_core_valid = 0;

  bit         hold_prev = 1'b0;
  logic [7:0] hold_data = '0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Behavioural core: answers core_lat cycles after the request pulse.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (core_valid) begin
      n_core_valid++;
      if (din_q.size() == 0) check("core_valid_unexpected", 1, 0);
      else check("core_din", core_din, din_q.pop_front());
      if (core_on) begin
        core_pend = 1'b1;
        core_cnt  = core_lat;
        core_cap  = core_din;
      end
    end else if (core_pend) begin
      core_cnt--;
    end
    if (core_pend && core_cnt == 0) begin
      core_done = 1'b1;
      core_dout = core_cap + 8'd1;
      core_pend = 1'b0;
    end
  end

  // Output monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (m_valid && hold_prev) check("m_data_stable", m_data, hold_data);
      hold_prev = m_valid && !m_ready;
      hold_data = m_data;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("m_valid_unexpected", 1, 0);
        else check("m_data", m_data, exp_q.pop_front());
      end
    end
  end

  task automatic push(input logic [7:0] b, input logic [7:0] exp_out, input logic [7:0] exp_din,
                      output int pc);
    exp_q.push_back(exp_out);
    if (exp_din != 8'h00) din_q.push_back(exp_din);
    s_valid = 1'b1;
    s_data  = b;
    pc      = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (s_ready) begin
        pc = cyc;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        return;
      end
    end
    check("push_timeout", 0, 1);
    s_valid = 1'b0;
  endtask

  task automatic wait_mvalid(output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (m_valid) begin
        c = cyc;
        return;
      end
    end
    check("wait_mvalid_timeout", 0, 1);
  endtask

  task automatic wait_core_valid(output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (core_valid) begin
        c = cyc;
        return;
      end
    end
    check("wait_core_valid_timeout", 0, 1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && din_q.size() == 0 && !busy) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    check({name, "_drain_timeout"}, 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pc, c1, c2, base;
    bit saw;
    logic [7:0] t2 [3];

    reset     = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b1;
    core_done = 1'b0;
    core_dout = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_core_valid", core_valid, 0);
    check("rst_core_din", core_din, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_char_count", char_count, 0);
    @(posedge clk);
    #1;

    // 1: "Ab" through a 3-cycle core
    core_lat = 3;
    push("A", "B", "A", pc);
    push("b", "c", "B", pc);
    wait_drain("t1");
    check("t1_char_count", char_count, 2);

    // 2: non-letters bypass the core with two-cycle latency
    base = n_core_valid;
    t2[0] = " ";
    t2[1] = "1";
    t2[2] = "!";
    for (int i = 0; i < 3; i++) begin
      push(t2[i], t2[i], 8'h00, pc);
      wait_mvalid(c1);
      check("t2_latency", c1 - pc, 2);
      wait_drain("t2");
    end
    check("t2_no_core_valid", n_core_valid - base, 0);

    // 3: slow core keeps '.' behind 'a'
    core_lat = 10;
    push("a", "b", "A", pc);
    push(".", ".", 8'h00, pc);
    push("B", "C", "B", pc);
    wait_drain("t3");
    check("t3_char_count", char_count, 8);

    // 4: silent core -> '?' after the timeout, then normal service
    core_on = 1'b0;
    push("x", "?", "X", pc);
    wait_core_valid(c1);
    wait_mvalid(c2);
    check("t4_timeout_cycles", c2 - c1, 65);
    check("t4_err_timeout", err_timeout, 1);
    wait_drain("t4a");
    core_on  = 1'b1;
    core_lat = 1;
    push("c", "d", "C", pc);
    wait_drain("t4b");
    check("t4_err_sticky", err_timeout, 1);

    // 5: back-pressure fills cur + FIFO, then drains in order
    m_ready  = 1'b0;
    core_lat = 2;
    push("k", "l", "K", pc);
    push("-", "-", 8'h00, pc);
    push("9", "9", 8'h00, pc);
    push("L", "M", "L", pc);
    push("m", "n", "M", pc);
    repeat (8) @(negedge clk);
    check("t5_s_ready_low", s_ready, 0);
    check("t5_m_valid", m_valid, 1);
    check("t5_m_data_head", m_data, "l");
    check("t5_busy", busy, 1);
    repeat (5) @(negedge clk);
    check("t5_m_data_held", m_data, "l");
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    push("?", "?", 8'h00, pc);
    wait_drain("t5");
    check("t5_char_count", char_count, 16);

    // 6: reset while waiting on the core; the late done must be dropped
    core_lat = 20;
    push("q", "r", "Q", pc);
    wait_core_valid(c1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    din_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      saw |= m_valid;
    end
    check("t6_no_m_valid", saw, 0);
    check("t6_core_answered", core_pend, 0);
    check("t6_busy", busy, 0);
    check("t6_char_count", char_count, 0);
    check("t6_s_ready", s_ready, 1);
    check("t6_err_timeout", err_timeout, 0);
    check("t6_core_din", core_din, 0);
    check("t6_m_data", m_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
